// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Runs 32 CALC cycles and one FIX cycle per operation. Divide-by-zero and signed overflow finish the cycle after the request.
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      MDUSel_i,
    input  logic [XLEN-1:0] DataA_i,
    input  logic [XLEN-1:0] DataB_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] mdu_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0]       OP_MUL  = 3'b000;
    localparam logic [2:0]       OP_MULH = 3'b001;
    localparam logic [2:0]       OP_MHSU = 3'b010;
    localparam logic [2:0]       OP_MULU = 3'b011;
    localparam logic [2:0]       OP_DIV  = 3'b100;
    localparam logic [2:0]       OP_DIVU = 3'b101;
    localparam logic [2:0]       OP_REM  = 3'b110;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_op;
    logic                r_sign_a;
    logic                r_sign_b;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN:0]       r_prem;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_mdu;

    logic                w_accept;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN:0]       w_mul_sum;
    logic [XLEN+1:0]     w_trial;
    logic                w_q;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_res;

    // Request decode works directly on the inputs; it only matters on the accepting edge.
    assign w_accept   = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_a_signed = (MDUSel_i == OP_MULH) || (MDUSel_i == OP_MHSU) ||
                        (MDUSel_i == OP_DIV)  || (MDUSel_i == OP_REM);
    assign w_b_signed = (MDUSel_i == OP_MULH) || (MDUSel_i == OP_DIV) || (MDUSel_i == OP_REM);
    assign w_sign_a   = w_a_signed && DataA_i[XLEN-1];
    assign w_sign_b   = w_b_signed && DataB_i[XLEN-1];
    assign w_mag_a    = w_sign_a ? -DataA_i : DataA_i;
    assign w_mag_b    = w_sign_b ? -DataB_i : DataB_i;

    assign w_div_zero = MDUSel_i[2] && (DataB_i == '0);
    assign w_ovf      = ((MDUSel_i == OP_DIV) || (MDUSel_i == OP_REM)) &&
                        (DataA_i == MIN_NEG) && (DataB_i == '1);
    assign w_special  = w_div_zero || w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = MDUSel_i[1] ? DataA_i : '1;
        end else if (w_ovf) begin
            w_special_res = MDUSel_i[1] ? '0 : MIN_NEG;
        end
    end

    // Multiply: low half holds the multiplier, high half accumulates, shift right each step.
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);

    // Divide: shift the next dividend bit into the partial remainder and try subtracting.
    assign w_trial = {r_prem, r_acc[XLEN-1]} - {2'b00, r_b};
    assign w_q     = ~w_trial[XLEN+1];

    assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quo  = (r_sign_a ^ r_sign_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_sign_a ? -r_prem[XLEN-1:0] : r_prem[XLEN-1:0];

    always_comb begin
        w_fix_res = w_rem;
        case (r_op)
            OP_MUL:                    w_fix_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MHSU, OP_MULU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:           w_fix_res = w_quo;
            default:                   w_fix_res = w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy_o = (r_state != S_IDLE);
        done_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // A flush abandons the operation from any state, including a pending done.
        if (flush_i) begin
            w_next = S_IDLE;
            done_o = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_prem   <= '0;
            r_cnt    <= '0;
            r_mdu    <= '0;
        end else if (w_accept) begin
            r_op     <= MDUSel_i;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_b      <= w_mag_b;
            r_acc    <= {{XLEN{1'b0}}, w_mag_a};
            r_prem   <= '0;
            r_cnt    <= CNT_MAX;
            if (w_special) begin
                r_mdu <= w_special_res;
            end
        end else if ((r_state == S_CALC) && !flush_i) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (r_op[2]) begin
                r_acc[XLEN-1:0] <= {r_acc[XLEN-2:0], w_q};
                r_prem          <= w_q ? w_trial[XLEN:0] : {r_prem[XLEN-1:0], r_acc[XLEN-1]};
            end else begin
                r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
            end
        end else if ((r_state == S_FIX) && !flush_i) begin
            r_mdu <= w_fix_res;
        end
    end

    assign mdu_o = r_mdu;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter: results, cycle-exact latency, handshake, flush and async reset.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [2:0]  MDUSel_i = 3'b000;
    logic [31:0] DataA_i = 32'h0;
    logic [31:0] DataB_i = 32'h0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] mdu_o;

    int n_tests = 0;
    int n_fail  = 0;

    mdu_iter #(.XLEN(32), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .MDUSel_i (MDUSel_i),
        .DataA_i  (DataA_i),
        .DataB_i  (DataB_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .mdu_o    (mdu_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drives start in cycle 0, scrambles the inputs afterwards,
    // and checks result, done cycle, single done pulse and busy over cycles 1..exp_lat.
    task automatic run_op(input string tag, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int poke_c);
        int          done_c;
        int          n_done;
        int          busy_bad;
        logic [31:0] res;
        done_c   = -1;
        n_done   = 0;
        busy_bad = 0;
        res      = 32'h0;
        MDUSel_i = sel;
        DataA_i  = a;
        DataB_i  = b;
        start_i  = 1'b1;
        flush_i  = 1'b0;
        for (int c = 1; c <= exp_lat + 1; c++) begin
            @(negedge clk);
            if (done_o) begin
                n_done++;
                if (done_c < 0) begin
                    done_c = c;
                    res    = mdu_o;
                end
            end
            if (c <= exp_lat && !busy_o) busy_bad++;
            if (c == exp_lat + 1) begin
                check_eq({tag, "_idle_after"}, 32'(busy_o), 32'h0);
            end else begin
                start_i  = (c == poke_c);
                MDUSel_i = sel ^ 3'b101;
                DataA_i  = a ^ 32'h1234_5678;
                DataB_i  = ~b;
            end
        end
        start_i = 1'b0;
        check_eq({tag, "_res"}, res, exp_res);
        check_eq({tag, "_done_cycle"}, 32'(done_c), 32'(exp_lat));
        check_eq({tag, "_done_pulses"}, 32'(n_done), 32'd1);
        check_eq({tag, "_busy_gaps"}, 32'(busy_bad), 32'd0);
    endtask

    initial begin
        int n_done;

        repeat (3) @(negedge clk);
        check_eq("reset_busy", 32'(busy_o), 32'h0);
        check_eq("reset_done", 32'(done_o), 32'h0);
        check_eq("reset_mdu", mdu_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul",     3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
        run_op("mulh",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
        run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
        run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
        run_op("div",     3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34, 0);
        run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34, 0);
        run_op("divu",    3'b101, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 34, 0);
        run_op("remu",    3'b111, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 34, 0);

        run_op("div_by0",  3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1, 0);
        run_op("remu_by0", 3'b111, 32'd5,        32'd0,        32'h0000_0005, 1, 0);
        run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);

        run_op("busy_start", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 5);

        // Flush in cycle 10 of a DIVU: idle from cycle 11, no done, result register untouched.
        n_done   = 0;
        MDUSel_i = 3'b101;
        DataA_i  = 32'd100;
        DataB_i  = 32'd3;
        start_i  = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (done_o) n_done++;
            if (c == 10) begin
                check_eq("flush_busy_c10", 32'(busy_o), 32'h1);
                flush_i = 1'b1;
            end
            if (c == 11) begin
                flush_i = 1'b0;
                check_eq("flush_busy_c11", 32'(busy_o), 32'h0);
            end
        end
        check_eq("flush_no_done", 32'(n_done), 32'd0);
        check_eq("flush_mdu_held", mdu_o, 32'hFFFF_FFEB);
        run_op("after_flush", 3'b101, 32'd100, 32'd3, 32'h0000_0021, 34, 0);

        // Flush wins over a simultaneous start in IDLE.
        MDUSel_i = 3'b000;
        DataA_i  = 32'd3;
        DataB_i  = 32'd3;
        start_i  = 1'b1;
        flush_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        flush_i = 1'b0;
        check_eq("flush_prio_busy", 32'(busy_o), 32'h0);
        check_eq("flush_prio_mdu", mdu_o, 32'h0000_0021);

        // Asynchronous reset between clock edges in the middle of CALC.
        MDUSel_i = 3'b101;
        DataA_i  = 32'd1000;
        DataB_i  = 32'd7;
        start_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("rst_pre_busy", 32'(busy_o), 32'h1);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_async_busy", 32'(busy_o), 32'h0);
        check_eq("rst_async_done", 32'(done_o), 32'h0);
        check_eq("rst_async_mdu", mdu_o, 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_release_busy", 32'(busy_o), 32'h0);
        run_op("after_rst", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
